seq_signed_divider: RTL and testbench

- Multi-cycle signed 32-bit integer divider for the processor's multiply/divide unit.
- Takes operands on a one-cycle start pulse and runs a 32-iteration non-restoring shift/add-subtract loop on magnitudes.
- Applies the result sign, then raises a ready flag.
- Flags divide-by-zero; the quotient truncates toward zero; no remainder output.

---
 rtl/seq_signed_divider_pkg.sv | 20 ++
 rtl/seq_signed_divider_ctrl.sv | 54 +++++
 rtl/seq_signed_divider.sv | 79 +++++++
 tb/tb_seq_signed_divider.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_signed_divider_pkg.sv
// Shared widths, FSM state encoding and counter sizing for the signed divider.
package seq_signed_divider_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must be able to hold the value ITERS itself.
    function automatic int cnt_width(input int iters);
        return $clog2(iters + 1);
    endfunction

    localparam int CNT_W = cnt_width(ITERS);

endpackage

// File: rtl/seq_signed_divider_ctrl.sv
// Sequencer for the divider: state, iteration counter, add/sub select, ready flag.
module div_ctrl_fsm
    import seq_signed_divider_pkg::*;
#(
    parameter int ITERS = seq_signed_divider_pkg::ITERS
) (
    input  logic clock,
    input  logic reset,
    input  logic ctrl_DIV,
    input  logic p_sign,
    output logic load,
    output logic step,
    output logic add_not_sub,
    output logic done
);

    localparam int CW = cnt_width(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic          rdy_q;

    // Control strobes to the datapath; a start always wins over an iteration.
    always_comb begin
        load        = ctrl_DIV & ~reset;
        step        = (state == RUN);
        add_not_sub = p_sign;
        done        = rdy_q;
    end

    // State, counter and registered ready flag; start restarts from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rdy_q <= 1'b0;
        end else if (ctrl_DIV) begin
            state <= RUN;
            cnt   <= '0;
            rdy_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= DONE;
                end
                DONE:    rdy_q <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: non-restoring division on magnitudes, sign applied at the end.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int WIDTH = seq_signed_divider_pkg::WIDTH,
    parameter int ITERS = seq_signed_divider_pkg::ITERS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             load, step, add_not_sub, done;
    logic [WIDTH:0]   p_q, p_sh, p_new, div_ext;
    logic [WIDTH-1:0] q_q, q_sh, div_q, mag_a, mag_b, q_signed;
    logic             sign_q, zero_q;

    div_ctrl_fsm #(.ITERS(ITERS)) u_ctrl (
        .clock       (clock),
        .reset       (reset),
        .ctrl_DIV    (ctrl_DIV),
        .p_sign      (p_q[WIDTH]),
        .load        (load),
        .step        (step),
        .add_not_sub (add_not_sub),
        .done        (done)
    );

    // Operand magnitudes; the most negative value maps to itself and is read as unsigned.
    always_comb begin
        mag_a = data_operandA[WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
        mag_b = data_operandB[WIDTH-1] ? (~data_operandB + ONE) : data_operandB;
    end

    // One non-restoring step: shift {P,Q}, then add or subtract the divisor by P's sign.
    // P stays within one divisor of zero, so its sign survives the shift unchanged.
    always_comb begin
        p_sh    = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_sh    = {q_q[WIDTH-2:0], 1'b0};
        div_ext = {1'b0, div_q};
        p_new   = add_not_sub ? (p_sh + div_ext) : (p_sh - div_ext);
    end

    // Working register and latched operand attributes.
    always_ff @(posedge clock) begin
        if (reset) begin
            p_q    <= '0;
            q_q    <= '0;
            div_q  <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (load) begin
            p_q    <= '0;
            q_q    <= mag_a;
            div_q  <= mag_b;
            sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            zero_q <= (data_operandB == '0);
        end else if (step) begin
            p_q <= p_new;
            q_q <= {q_sh[WIDTH-1:1], ~p_new[WIDTH]};
        end
    end

    // Results are driven only once ready; the working register is frozen in DONE.
    always_comb begin
        q_signed       = sign_q ? (~q_q + ONE) : q_q;
        data_resultRDY = done;
        data_exception = done & zero_q;
        data_result    = (done && !zero_q) ? q_signed : '0;
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: cycle-level interface model plus directed literals.
module tb_seq_signed_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    // Directed literal expectation handed to the checker with each start.
    logic [31:0] lit_res = '0;
    logic        lit_exc = 1'b0;
    logic        lit_en  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_signed_divider dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Reference: truncating signed division in 64 bits, low 32 bits kept; B=0 -> 0 with exception.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint q;
        if (b == 32'd0) return {1'b1, 32'd0};
        q = longint'($signed(a)) / longint'($signed(b));
        return {1'b0, q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Checker: at every falling edge compare outputs, then account for what the next rising edge samples.
    logic        armed = 1'b0;
    logic        active = 1'b0;
    int          edges = 0;
    logic [31:0] exp_res = '0;
    logic        exp_exc = 1'b0;
    logic [31:0] cap_lit_res = '0;
    logic        cap_lit_exc = 1'b0;
    logic        cap_lit_en  = 1'b0;

    always @(negedge clock) begin
        logic [32:0] m;
        if (armed) begin
            if (!active) begin
                chk("idle_rdy", {31'd0, data_resultRDY}, 32'd0);
                chk("idle_result", data_result, 32'd0);
                chk("idle_exc", {31'd0, data_exception}, 32'd0);
            end else if (edges < 33) begin
                chk("busy_rdy", {31'd0, data_resultRDY}, 32'd0);
                chk("busy_result", data_result, 32'd0);
                chk("busy_exc", {31'd0, data_exception}, 32'd0);
            end else begin
                chk("done_rdy", {31'd0, data_resultRDY}, 32'd1);
                chk("done_result", data_result, exp_res);
                chk("done_exc", {31'd0, data_exception}, {31'd0, exp_exc});
                if (cap_lit_en && edges == 33) begin
                    chk("literal_result", data_result, cap_lit_res);
                    chk("literal_exc", {31'd0, data_exception}, {31'd0, cap_lit_exc});
                end
            end
        end
        if (reset) begin
            armed  = 1'b1;
            active = 1'b0;
        end else if (ctrl_DIV) begin
            m           = model(data_operandA, data_operandB);
            exp_res     = m[31:0];
            exp_exc     = m[32];
            cap_lit_res = lit_res;
            cap_lit_exc = lit_exc;
            cap_lit_en  = lit_en;
            active      = 1'b1;
            edges       = 0;
        end else if (edges < 40) begin
            edges = edges + 1;
        end
    end

    // Drive a one-cycle start pulse, then scramble the operands to show they are ignored.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lr, input logic le, input logic len);
        @(posedge clock); #2;
        data_operandA = a;
        data_operandB = b;
        lit_res  = lr;
        lit_exc  = le;
        lit_en   = len;
        ctrl_DIV = 1'b1;
        @(posedge clock); #2;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lr, input logic le, input logic len);
        start(a, b, lr, le, len);
        repeat (35) @(posedge clock);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] ra, rb;
        vecs[0] = '{32'd7,        32'd2,        32'd3,        1'b0};
        vecs[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0};
        vecs[4] = '{32'd0,        32'd5,        32'd0,        1'b0};
        vecs[5] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};
        vecs[6] = '{32'd10,       32'd0,        32'd0,        1'b1};
        vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[8] = '{32'h80000000, 32'd2,        32'hC0000000, 1'b0};
        vecs[9] = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};

        repeat (3) @(posedge clock);
        #2 reset = 1'b0;

        foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, 1'b1);

        // Restart mid-run: 100/7 interrupted at iteration 10 by 9/3.
        start(32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        repeat (9) @(posedge clock);
        run(32'd9, 32'd3, 32'd3, 1'b0, 1'b1);

        // Restart from DONE.
        run(32'd21, 32'd4, 32'd5, 1'b0, 1'b1);

        // Reset at iteration 5 aborts and leaves the block idle.
        start(32'd50, 32'd5, 32'd10, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        repeat (40) @(posedge clock);

        // Reset and start on the same edge: reset wins.
        @(posedge clock); #2;
        reset = 1'b1; ctrl_DIV = 1'b1; data_operandA = 32'd8; data_operandB = 32'd2;
        @(posedge clock); #2;
        reset = 1'b0; ctrl_DIV = 1'b0;
        repeat (40) @(posedge clock);

        // Randomised operand pairs, mixing full-range and small divisors and zero.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = ($urandom_range(0, 19) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
                2:       rb = -32'($urandom_range(1, 1000));
                default: rb = 32'($urandom_range(1, 65535));
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            run(ra, rb, 32'd0, 1'b0, 1'b0);
        end

        @(negedge clock);
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
